// File: rtl/aimc_lib.sv
// Shared definitions for the AIMC clocking blocks: PLL bring-up sequencer
// state encoding and its default timing constants.
package aimc_lib;

  typedef enum logic [2:0] {
    IDLE,
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    GATE,
    READY,
    RETRY,
    FAIL
  } pll_seq_state_t;

  localparam int unsigned PLL_SEQ_RST_CYCLES    = 64;
  localparam int unsigned PLL_SEQ_LOCK_TIMEOUT  = 65535;
  localparam int unsigned PLL_SEQ_STABLE_CYCLES = 256;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/xiphy_pll_seq.sv
// XIPHY PLL bring-up sequencer: MMCM lock -> PLL reset -> lock qualify ->
// CLKOUTPHY gate -> PHY reset release, with bounded retries and lock monitoring.
module xiphy_pll_seq
  import aimc_lib::*;
#(
  parameter int unsigned RST_CYCLES    = PLL_SEQ_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = PLL_SEQ_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = PLL_SEQ_STABLE_CYCLES,
  parameter int unsigned GATE_CYCLES   = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                           clk_div,
  input  logic                           rst_div,
  input  logic                           mmcm_lock,
  input  logic                           pll_lock,
  input  logic                           recal_req,
  output logic                           pll_rst,
  output logic                           pll_gate,
  output logic                           phy_rst,
  output logic                           phy_ready,
  output logic                           seq_fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [2:0]                     seq_state
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRY);

  logic ml_s;
  logic pl_s;

  pll_seq_state_t   state_q;
  pll_seq_state_t   state_nx;
  logic [CNT_W-1:0] timer_q;
  logic [RW-1:0]    retry_q;
  logic [RW-1:0]    retry_nx;

  sync_2ff u_sync_mmcm (
    .clk (clk_div),
    .rst (rst_div),
    .d   (mmcm_lock),
    .q   (ml_s)
  );

  sync_2ff u_sync_pll (
    .clk (clk_div),
    .rst (rst_div),
    .d   (pll_lock),
    .q   (pl_s)
  );

  always_comb begin
    state_nx = state_q;
    retry_nx = retry_q;
    case (state_q)
      IDLE: begin
        if (ml_s) state_nx = PLL_RST;
      end
      PLL_RST: begin
        if (timer_q == RST_LAST) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (pl_s) begin
          state_nx = STABLE;
        end else if (timer_q == LOCK_LAST) begin
          state_nx = RETRY;
          retry_nx = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;
        end
      end
      STABLE: begin
        if (!pl_s) state_nx = WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_nx = GATE;
      end
      GATE: begin
        if (timer_q == GATE_LAST) state_nx = READY;
      end
      READY: begin
        // Lock loss takes priority over a concurrent recalibration request.
        if (!pl_s) begin
          state_nx = RETRY;
          retry_nx = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;
        end else if (recal_req) begin
          state_nx = PLL_RST;
          retry_nx = '0;
        end
      end
      RETRY: begin
        state_nx = (retry_q == RETRY_MAX) ? FAIL : PLL_RST;
      end
      FAIL: begin
        if (recal_req) begin
          state_nx = PLL_RST;
          retry_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // MMCM loss aborts any active bring-up without touching the retry count.
    if (!ml_s && state_q != IDLE && state_q != FAIL) begin
      state_nx = IDLE;
      retry_nx = retry_q;
    end
  end

  always_ff @(posedge clk_div or posedge rst_div) begin
    if (rst_div) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      pll_rst   <= 1'b1;
      pll_gate  <= 1'b0;
      phy_rst   <= 1'b1;
      phy_ready <= 1'b0;
      seq_fail  <= 1'b0;
    end else begin
      state_q <= state_nx;
      retry_q <= retry_nx;
      if (state_nx != state_q) timer_q <= '0;
      else if (timer_q != '1)  timer_q <= timer_q + 1'b1;
      // Outputs decode the next state so they switch together with state_q.
      pll_rst   <= (state_nx == IDLE) || (state_nx == PLL_RST) || (state_nx == FAIL);
      pll_gate  <= (state_nx == GATE) || (state_nx == READY);
      phy_rst   <= (state_nx != READY);
      phy_ready <= (state_nx == READY);
      seq_fail  <= (state_nx == FAIL);
    end
  end

  assign retry_cnt = retry_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_xiphy_pll_seq.sv
// Directed bench for xiphy_pll_seq with short timing parameters.
module tb_xiphy_pll_seq;
  import aimc_lib::*;

  logic       clk_div = 1'b0;
  logic       rst_div;
  logic       mmcm_lock;
  logic       pll_lock;
  logic       recal_req;
  logic       pll_rst;
  logic       pll_gate;
  logic       phy_rst;
  logic       phy_ready;
  logic       seq_fail;
  logic [1:0] retry_cnt;
  logic [2:0] seq_state;

  int cyc;
  int n_chk;
  int n_fail;

  // {pll_rst, pll_gate, phy_rst, phy_ready, seq_fail, retry_cnt, seq_state}
  localparam logic [9:0] RST_VEC = 10'b1_0_1_0_0_00_000;

  xiphy_pll_seq #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .GATE_CYCLES   (2),
    .MAX_RETRY     (2),
    .CNT_W         (8)
  ) dut (
    .clk_div   (clk_div),
    .rst_div   (rst_div),
    .mmcm_lock (mmcm_lock),
    .pll_lock  (pll_lock),
    .recal_req (recal_req),
    .pll_rst   (pll_rst),
    .pll_gate  (pll_gate),
    .phy_rst   (phy_rst),
    .phy_ready (phy_ready),
    .seq_fail  (seq_fail),
    .retry_cnt (retry_cnt),
    .seq_state (seq_state)
  );

  always #5 clk_div = ~clk_div;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_div);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Reset released just after an edge; that moment is cycle 0.
  task automatic do_reset();
    rst_div   = 1'b1;
    mmcm_lock = 1'b0;
    pll_lock  = 1'b0;
    recal_req = 1'b0;
    repeat (3) @(posedge clk_div);
    #1;
    rst_div = 1'b0;
    cyc     = 0;
  endtask

  // Nominal bring-up stimulus: READY is reached at cycle 23.
  task automatic bring_up();
    do_reset();
    mmcm_lock = 1'b1;
    run_to(10);
    pll_lock = 1'b1;
    run_to(23);
  endtask

  task automatic test_reset();
    rst_div   = 1'b1;
    mmcm_lock = 1'b0;
    pll_lock  = 1'b0;
    recal_req = 1'b0;
    #2;
    n_chk++;
    if ({pll_rst, pll_gate, phy_rst, phy_ready, seq_fail, retry_cnt, seq_state} !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected %b",
               {pll_rst, pll_gate, phy_rst, phy_ready, seq_fail, retry_cnt, seq_state}, RST_VEC);
    end
    do_reset();
    run_to(10);
    n_chk++;
    if ({pll_rst, pll_gate, phy_rst, phy_ready, seq_fail, retry_cnt, seq_state} !== RST_VEC) begin
      n_fail++;
      $display("FAIL idle_without_mmcm: got %b expected %b",
               {pll_rst, pll_gate, phy_rst, phy_ready, seq_fail, retry_cnt, seq_state}, RST_VEC);
    end
  endtask

  task automatic test_nominal();
    int rl = -1;
    int gl = -1;
    int rd = -1;
    do_reset();
    mmcm_lock = 1'b1;
    while (cyc < 60 && rd < 0) begin
      if (cyc == 10) pll_lock = 1'b1;
      tick();
      if (!pll_rst && rl < 0) rl = cyc;
      if (pll_gate && gl < 0) gl = cyc;
      if (phy_ready && rd < 0) rd = cyc;
    end
    n_chk++;
    if (rl !== 7) begin n_fail++; $display("FAIL nominal_pll_rst_low: cycle %0d expected 7", rl); end
    n_chk++;
    if (gl !== 21) begin n_fail++; $display("FAIL nominal_gate: cycle %0d expected 21", gl); end
    n_chk++;
    if (rd !== 23) begin n_fail++; $display("FAIL nominal_ready: cycle %0d expected 23", rd); end
    n_chk++;
    if (phy_rst !== 1'b0) begin n_fail++; $display("FAIL nominal_phy_rst: got %b expected 0", phy_rst); end
    n_chk++;
    if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL nominal_retry: got %0d expected 0", retry_cnt); end
    n_chk++;
    if (seq_state !== READY) begin n_fail++; $display("FAIL nominal_state: got %0d expected %0d", seq_state, READY); end
  endtask

  task automatic test_timeout();
    logic       rst_h [0:63];
    logic [1:0] rc_h  [0:63];
    logic       fail_h[0:63];
    int         bad = -1;
    do_reset();
    mmcm_lock = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rst_h[i]  = pll_rst;
      rc_h[i]   = retry_cnt;
      fail_h[i] = seq_fail;
      if (i < 63) tick();
    end
    // pll_rst: high 0..6, low in WAIT_LOCK 7..26 and RETRY 27, high 28..31,
    // low 32..52, high in FAIL from 53.
    for (int i = 0; i < 64; i++) begin
      if (rst_h[i] !== ((i < 7) || (i >= 28 && i <= 31) || (i >= 53)) && bad < 0) bad = i;
    end
    n_chk++;
    if (bad !== -1) begin n_fail++; $display("FAIL timeout_pll_rst_profile: first wrong cycle %0d expected none", bad); end
    n_chk++;
    if (rc_h[26] !== 2'd0) begin n_fail++; $display("FAIL timeout_retry_c26: got %0d expected 0", rc_h[26]); end
    n_chk++;
    if (rc_h[27] !== 2'd1) begin n_fail++; $display("FAIL timeout_retry_c27: got %0d expected 1", rc_h[27]); end
    n_chk++;
    if (rc_h[51] !== 2'd1) begin n_fail++; $display("FAIL timeout_retry_c51: got %0d expected 1", rc_h[51]); end
    n_chk++;
    if (rc_h[52] !== 2'd2) begin n_fail++; $display("FAIL timeout_retry_c52: got %0d expected 2", rc_h[52]); end
    n_chk++;
    if (fail_h[52] !== 1'b0) begin n_fail++; $display("FAIL timeout_fail_c52: got %b expected 0", fail_h[52]); end
    n_chk++;
    if (fail_h[53] !== 1'b1) begin n_fail++; $display("FAIL timeout_fail_c53: got %b expected 1", fail_h[53]); end
    run_to(90);
    n_chk++;
    if ({seq_fail, pll_rst, phy_ready, pll_gate, phy_rst, retry_cnt, seq_state} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'd7}) begin
      n_fail++;
      $display("FAIL timeout_fail_persist: got %b expected %b",
               {seq_fail, pll_rst, phy_ready, pll_gate, phy_rst, retry_cnt, seq_state},
               {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'd7});
    end
  endtask

  task automatic test_glitch();
    int gl = -1;
    int rd = -1;
    logic [2:0] st18 = '0;
    logic [2:0] st19 = '0;
    do_reset();
    mmcm_lock = 1'b1;
    while (cyc < 60 && rd < 0) begin
      if (cyc == 10) pll_lock = 1'b1;
      if (cyc == 16) pll_lock = 1'b0;
      if (cyc == 17) pll_lock = 1'b1;
      tick();
      if (cyc == 18) st18 = seq_state;
      if (cyc == 19) st19 = seq_state;
      if (pll_gate && gl < 0) gl = cyc;
      if (phy_ready && rd < 0) rd = cyc;
    end
    n_chk++;
    if (st18 !== STABLE) begin n_fail++; $display("FAIL glitch_state_c18: got %0d expected %0d", st18, STABLE); end
    n_chk++;
    if (st19 !== WAIT_LOCK) begin n_fail++; $display("FAIL glitch_state_c19: got %0d expected %0d", st19, WAIT_LOCK); end
    n_chk++;
    if (gl !== 28) begin n_fail++; $display("FAIL glitch_gate: cycle %0d expected 28", gl); end
    n_chk++;
    if (rd !== 30) begin n_fail++; $display("FAIL glitch_ready: cycle %0d expected 30", rd); end
    n_chk++;
    if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL glitch_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_lock_loss();
    int rd = -1;
    bring_up();
    run_to(30);
    pll_lock = 1'b0;
    run_to(32);
    n_chk++;
    if (phy_ready !== 1'b1) begin n_fail++; $display("FAIL loss_ready_c32: got %b expected 1", phy_ready); end
    tick();
    n_chk++;
    if ({phy_ready, phy_rst, pll_gate, retry_cnt, seq_state} !== {1'b0, 1'b1, 1'b0, 2'd1, 3'd6}) begin
      n_fail++;
      $display("FAIL loss_retry_c33: got %b expected %b",
               {phy_ready, phy_rst, pll_gate, retry_cnt, seq_state}, {1'b0, 1'b1, 1'b0, 2'd1, 3'd6});
    end
    run_to(40);
    pll_lock = 1'b1;
    while (cyc < 80 && rd < 0) begin
      tick();
      if (phy_ready && rd < 0) rd = cyc;
    end
    n_chk++;
    if (rd !== 53) begin n_fail++; $display("FAIL loss_reready: cycle %0d expected 53", rd); end
    n_chk++;
    if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL loss_retry_kept: got %0d expected 1", retry_cnt); end
  endtask

  // Continues from READY at cycle 53 left by test_lock_loss.
  task automatic test_back_to_back();
    int rd = -1;
    run_to(60);
    recal_req = 1'b1;
    tick();
    recal_req = 1'b0;
    n_chk++;
    if ({seq_state, retry_cnt, pll_rst, pll_gate, phy_ready} !== {3'd1, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL recal_ready_c61: got %b expected %b",
               {seq_state, retry_cnt, pll_rst, pll_gate, phy_ready}, {3'd1, 2'd0, 1'b1, 1'b0, 1'b0});
    end
    while (cyc < 100 && rd < 0) begin
      tick();
      if (phy_ready && rd < 0) rd = cyc;
    end
    n_chk++;
    if (rd !== 76) begin n_fail++; $display("FAIL recal_reready: cycle %0d expected 76", rd); end
    run_to(80);
    pll_lock = 1'b0;
    run_to(82);
    recal_req = 1'b1;
    n_chk++;
    if (seq_state !== READY) begin n_fail++; $display("FAIL both_state_c82: got %0d expected %0d", seq_state, READY); end
    tick();
    recal_req = 1'b0;
    n_chk++;
    if ({seq_state, retry_cnt} !== {3'd6, 2'd1}) begin
      n_fail++;
      $display("FAIL both_retry_wins: got %b expected %b", {seq_state, retry_cnt}, {3'd6, 2'd1});
    end
    tick();
    n_chk++;
    if (seq_state !== PLL_RST) begin n_fail++; $display("FAIL both_after_retry: got %0d expected %0d", seq_state, PLL_RST); end
  endtask

  task automatic test_mmcm_recal();
    do_reset();
    mmcm_lock = 1'b1;
    run_to(35);
    mmcm_lock = 1'b0;
    run_to(37);
    n_chk++;
    if (seq_state !== WAIT_LOCK) begin n_fail++; $display("FAIL mmcm_state_c37: got %0d expected %0d", seq_state, WAIT_LOCK); end
    tick();
    n_chk++;
    if ({seq_state, pll_rst, retry_cnt} !== {3'd0, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL mmcm_loss_idle: got %b expected %b", {seq_state, pll_rst, retry_cnt}, {3'd0, 1'b1, 2'd1});
    end
    run_to(40);
    mmcm_lock = 1'b1;
    run_to(43);
    n_chk++;
    if (seq_state !== PLL_RST) begin n_fail++; $display("FAIL mmcm_restart_c43: got %0d expected %0d", seq_state, PLL_RST); end
    run_to(68);
    n_chk++;
    if ({seq_state, seq_fail, retry_cnt} !== {3'd7, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL mmcm_fail_c68: got %b expected %b", {seq_state, seq_fail, retry_cnt}, {3'd7, 1'b1, 2'd2});
    end
    run_to(72);
    recal_req = 1'b1;
    tick();
    recal_req = 1'b0;
    n_chk++;
    if ({seq_state, seq_fail, retry_cnt, pll_rst} !== {3'd1, 1'b0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL recal_from_fail: got %b expected %b", {seq_state, seq_fail, retry_cnt, pll_rst}, {3'd1, 1'b0, 2'd0, 1'b1});
    end
    run_to(77);
    n_chk++;
    if ({seq_state, pll_rst} !== {3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL recal_wait_lock: got %b expected %b", {seq_state, pll_rst}, {3'd2, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    bring_up();
    run_to(25);
    n_chk++;
    if (phy_ready !== 1'b1) begin n_fail++; $display("FAIL async_pre_ready: got %b expected 1", phy_ready); end
    #2;
    rst_div = 1'b1;
    #1;
    n_chk++;
    if ({pll_rst, pll_gate, phy_rst, phy_ready, seq_fail, retry_cnt, seq_state} !== RST_VEC) begin
      n_fail++;
      $display("FAIL async_reset_values: got %b expected %b",
               {pll_rst, pll_gate, phy_rst, phy_ready, seq_fail, retry_cnt, seq_state}, RST_VEC);
    end
    @(posedge clk_div);
    #1;
    rst_div = 1'b0;
    tick();
    n_chk++;
    if ({pll_rst, phy_ready, seq_state} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL async_after_release: got %b expected %b", {pll_rst, phy_ready, seq_state}, {1'b1, 1'b0, 3'd0});
    end
  endtask

  initial begin
    cyc    = 0;
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_nominal();
    test_timeout();
    test_glitch();
    test_lock_loss();
    test_back_to_back();
    test_mmcm_recal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
